// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external 32-bit ALU: 8-entry register file, single-cycle
// ALU ops, and a shift-add MUL (selector 4'b1000) built from ALU add and shift-left.
module alu_op_sequencer #(
  parameter int REG_AW = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  output logic              done,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y
);
  localparam int NREG = 1 << REG_AW;
  localparam int IW   = $clog2(DATA_W);
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] SEL_NOP  = 4'b1111;
  localparam logic [3:0] SEL_PASS = 4'b0000;
  localparam logic [3:0] SEL_ADD  = 4'b0100;
  localparam logic [3:0] SEL_SHL  = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC, MUL_ADD, MUL_SHIFT} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] opa, opb, acc;  // for MUL, opa is the multiplicand and opb the multiplier
  logic [IW-1:0]     iter;
  logic              accept, mul_last, wb;
  logic [DATA_W-1:0] wb_data;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign mul_last  = ((opb >> 1) == '0) || (iter == IW'(DATA_W-1));
  assign wb        = (state == EXEC) || (state == MUL_SHIFT && mul_last);
  assign wb_data   = (state == EXEC) ? alu_y : acc;
  assign rd_data   = regs[rd_addr];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = (cmd_op == OP_MUL) ? MUL_ADD : EXEC;
      EXEC:      state_nxt = IDLE;
      MUL_ADD:   state_nxt = MUL_SHIFT;
      MUL_SHIFT: state_nxt = mul_last ? IDLE : MUL_ADD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_sel = SEL_NOP;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      EXEC:      begin alu_sel = op_q; alu_a = opa; alu_b = opb; end
      MUL_ADD:   begin alu_sel = opb[0] ? SEL_ADD : SEL_PASS; alu_a = acc; alu_b = opa; end
      MUL_SHIFT: begin alu_sel = SEL_SHL; alu_a = opa; end
      default:   ;
    endcase
  end

  // Writeback only happens outside IDLE and loads only inside it, so they never collide.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb) begin
      regs[rd_q] <= wb_data;
    end else if (state == IDLE && wr_en) begin
      regs[wr_addr] <= wr_data;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q    <= SEL_NOP;
      rd_q    <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      iter    <= '0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      done    <= wb;
      wr_drop <= wr_en && (state != IDLE);
      case (state)
        IDLE: if (accept) begin
          op_q <= cmd_op;
          rd_q <= cmd_rd;
          opa  <= regs[cmd_ra];
          opb  <= regs[cmd_rb];
          acc  <= '0;
          iter <= '0;
        end
        MUL_ADD: acc <= alu_y;
        MUL_SHIFT: begin
          opa  <= alu_y;
          opb  <= opb >> 1;
          iter <= iter + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed commands, scoreboard checked on done.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic        done;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_drop;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_y;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_sel(alu_sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  // Behavioural ALU for the selector codes this bench exercises.
  always_comb
    case (alu_sel)
      4'b0000: alu_y = alu_a;
      4'b0100: alu_y = alu_a + alu_b;
      4'b0110: alu_y = alu_a - alu_b;
      4'b1101: alu_y = alu_a << 1;
      4'b1111: alu_y = '0;
      default: alu_y = alu_a ^ alu_b;
    endcase

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] val; int cyc; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding command.
  always @(negedge clk)
    if (rst_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("wb_value", rd_data, e.val);
      end
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Drive one command; rd_addr follows rd so the monitor reads the result on done.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [31:0] exp, input int lat,
                       input bit push);
    chk("ready_at_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    step();
    cmd_valid = 1'b0;
    rd_addr = rd;
    if (push) q.push_back('{exp, cyc + lat});
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < bound) begin step(); n++; end
    if (n >= bound) chk("wait_timeout", 32'd1, 32'd0);
    step();
  endtask

  initial begin
    logic [3:0] seq [6];
    seq = '{4'b0000, 4'b1101, 4'b0100, 4'b1101, 4'b0100, 4'b1101};

    #2;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_drop", wr_drop, 1'b0);
    chk("rst_sel", alu_sel, 4'b1111);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // ADD
    load(3'd1, 32'd5); load(3'd2, 32'd3);
    issue(4'b0100, 3'd3, 3'd1, 3'd2, 32'd8, 1, 1'b1);
    chk("exec_sel", alu_sel, 4'b0100);
    chk("exec_a", alu_a, 32'd5);
    chk("exec_b", alu_b, 32'd3);
    chk("exec_ready_low", cmd_ready, 1'b0);
    step();
    chk("add_done", done, 1'b1);
    chk("add_ready_back", cmd_ready, 1'b1);
    wait_idle(20);

    // SUB then back-to-back op 1111 in the done cycle
    load(3'd1, 32'd3); load(3'd2, 32'd5);
    issue(4'b0110, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFE, 1, 1'b1);
    step();
    chk("sub_done", done, 1'b1);
    issue(4'b1111, 3'd1, 3'd1, 3'd2, 32'd0, 1, 1'b1);
    chk("b2b_exec", cmd_ready, 1'b0);
    wait_idle(20);

    // MUL 7 x 6
    load(3'd4, 32'd7); load(3'd5, 32'd6);
    issue(4'b1000, 3'd6, 3'd4, 3'd5, 32'd42, 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("mul_sel_seq", alu_sel, seq[i]);
      chk("mul_busy", cmd_ready, 1'b0);
      step();
    end
    chk("mul_ready_back", cmd_ready, 1'b1);
    wait_idle(20);

    // MUL edge cases
    load(3'd1, 32'd3);
    issue(4'b1000, 3'd7, 3'd1, 3'd0, 32'd0, 2, 1'b1);
    wait_idle(20);
    load(3'd5, 32'h8000_0000);
    issue(4'b1000, 3'd7, 3'd1, 3'd5, 32'h8000_0000, 64, 1'b1);
    wait_idle(100);
    load(3'd2, 32'd9);
    issue(4'b1000, 3'd2, 3'd2, 3'd2, 32'd81, 8, 1'b1);
    wait_idle(30);

    // Load dropped while busy, honoured in IDLE
    load(3'd5, 32'd6);
    issue(4'b1000, 3'd6, 3'd4, 3'd5, 32'd42, 6, 1'b1);
    load(3'd6, 32'h0000_DEAD);
    chk("drop_pulse", wr_drop, 1'b1);
    step();
    chk("drop_clear", wr_drop, 1'b0);
    wait_idle(20);
    chk("r6_kept", rd_data, 32'd42);
    load(3'd6, 32'h0000_DEAD);
    chk("idle_no_drop", wr_drop, 1'b0);
    chk("idle_load", rd_data, 32'h0000_DEAD);

    // Reset in the middle of a MUL
    issue(4'b1000, 3'd3, 3'd4, 3'd5, 32'd42, 6, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_sel", alu_sel, 4'b1111);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r); #1;
      chk("midrst_reg_zero", rd_data, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("midrst_no_done", done, 1'b0);
      step();
    end

    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
